reg_mem_responder: RTL

Register-memory responder that terminates the read and write bus interfaces driven by the register interconnect (its `r_mem`/`w_mem` side). It holds a RAM_DEPTH x DATA_WIDTH register file and answers each `valid` request with a single-cycle `ready`, returning read data on the read bus. Read and write channels are independent and can be served concurrently.

---
 rtl/reg_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_mem_responder.sv
// -----------------------------------------------------------------------------
// reg_mem_responder
// Terminates the register interconnect's read and write buses with a
// RAM_DEPTH x DATA_WIDTH register file. Each accepted request gets exactly one
// single-cycle ready pulse. Read and write channels run independent FSMs and
// may be served in the same cycle. Both channels are return-to-zero: a new
// request is only taken after valid has been seen low.
//
// Build option: define REG_MEM_WR_FIRST_EN for write-first collision
// behaviour (read returns the data being written at the same edge).
// Otherwise the read returns the old contents and no bypass mux exists.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   r_bus_addr_i   read address
//   r_bus_valid_i  read request
//   r_bus_data_o   read data, meaningful while r_bus_ready_o = 1
//   r_bus_ready_o  read response pulse (2 cycles after valid is sampled)
//   w_bus_addr_i   write address
//   w_bus_data_i   write data
//   w_bus_valid_i  write request
//   w_bus_ready_o  write response pulse (1 cycle after valid is sampled)
// -----------------------------------------------------------------------------
module reg_mem_responder #(
   parameter int  DATA_WIDTH   = 32,
   parameter int  RAM_DEPTH    = 256,
   localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LB_RAM_DEPTH-1:0] r_bus_addr_i,
   input  logic                    r_bus_valid_i,
   output logic [DATA_WIDTH-1:0]   r_bus_data_o,
   output logic                    r_bus_ready_o,
   input  logic [LB_RAM_DEPTH-1:0] w_bus_addr_i,
   input  logic [DATA_WIDTH-1:0]   w_bus_data_i,
   input  logic                    w_bus_valid_i,
   output logic                    w_bus_ready_o
);

   typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP, R_WAIT} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_RESP, W_WAIT} w_state_t;

   // Register file: no reset, contents survive rst. Zero contents come from
   // the device configuration image, not from logic here.
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   r_state_t                r_state_q, r_state_d;
   logic [LB_RAM_DEPTH-1:0] r_addr_q, r_addr_d;
   logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
   logic                    r_ready_q, r_ready_d;
   logic                    rd_en;
   logic [DATA_WIDTH-1:0]   rd_word;

   w_state_t                w_state_q, w_state_d;
   logic                    w_ready_q, w_ready_d;
   logic                    wr_en;

   // ---------------------------------------------------------------- write FSM
   always_comb begin
      w_state_d = w_state_q;
      w_ready_d = 1'b0;
      wr_en     = 1'b0;
      case (w_state_q)
         W_IDLE: if (w_bus_valid_i) begin
            wr_en     = 1'b1;           // commit on the sampling edge
            w_ready_d = 1'b1;
            w_state_d = W_RESP;
         end
         W_RESP: w_state_d = w_bus_valid_i ? W_WAIT : W_IDLE;
         W_WAIT: if (!w_bus_valid_i) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_ready_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_ready_q <= w_ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[w_bus_addr_i] <= w_bus_data_i;
   end

   // ----------------------------------------------------------------- read FSM
`ifdef REG_MEM_WR_FIRST_EN
   // A write landing on the same edge the read samples the array wins.
   assign rd_word = (wr_en && (w_bus_addr_i == r_addr_q)) ? w_bus_data_i
                                                          : mem[r_addr_q];
`else
   assign rd_word = mem[r_addr_q];
`endif

   always_comb begin
      r_state_d = r_state_q;
      r_addr_d  = r_addr_q;
      r_ready_d = 1'b0;
      rd_en     = 1'b0;
      case (r_state_q)
         R_IDLE: if (r_bus_valid_i) begin
            r_addr_d  = r_bus_addr_i;
            r_state_d = R_READ;
         end
         R_READ: begin
            rd_en     = 1'b1;
            r_ready_d = 1'b1;
            r_state_d = R_RESP;
         end
         R_RESP: r_state_d = r_bus_valid_i ? R_WAIT : R_IDLE;
         R_WAIT: if (!r_bus_valid_i) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
      r_data_d = rd_en ? rd_word : r_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_data_q  <= '0;
         r_ready_q <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_data_q  <= r_data_d;
         r_ready_q <= r_ready_d;
      end
   end

   assign r_bus_data_o  = r_data_q;
   assign r_bus_ready_o = r_ready_q;
   assign w_bus_ready_o = w_ready_q;

endmodule
